// File: rtl/switch_tx_trigger_if.sv
// Button-to-UART trigger bus: debounced button and data switches in,
// transmitter handshake and status counters out.
interface switch_tx_trigger_if #(
  parameter int DATA_W = 8
);
  logic              btn_level;
  logic [DATA_W-1:0] data_in;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              press_pulse;
  logic [7:0]        send_count;
  logic [7:0]        drop_count;
  logic              timeout_err;

  modport master (
    output btn_level, data_in, tx_busy,
    input  tx_start, tx_data, press_pulse, send_count, drop_count, timeout_err
  );

  modport slave (
    input  btn_level, data_in, tx_busy,
    output tx_start, tx_data, press_pulse, send_count, drop_count, timeout_err
  );
endinterface

// File: rtl/switch_tx_trigger.sv
// Turns each debounced button press into one UART frame request, with accept
// timeout, post-frame gap, and saturating sent/dropped press counters.
module switch_tx_trigger #(
  parameter int DATA_W         = 8,
  parameter int ACCEPT_TIMEOUT = 16,
  parameter int GAP_CYCLES     = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  switch_tx_trigger_if.slave bus
);
  localparam int TO_W  = $clog2(ACCEPT_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic              btn_prev_r;
  logic [TO_W-1:0]   wait_cnt_r;
  logic [TO_W-1:0]   wait_cnt_nxt_s;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_nxt_s;
  logic              rise_s;
  logic              accept_s;
  logic              drop_s;
  logic              done_s;
  logic              timeout_s;
  logic              tx_start_r;
  logic              press_pulse_r;
  logic [DATA_W-1:0] tx_data_r;
  logic [7:0]        send_count_r;
  logic [7:0]        drop_count_r;
  logic              timeout_err_r;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next-state logic: edge detect, handshake progress and timers.
  always_comb begin
    rise_s         = bus.btn_level & ~btn_prev_r;
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    gap_cnt_nxt_s  = gap_cnt_r;
    accept_s       = 1'b0;
    done_s         = 1'b0;
    timeout_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s && !bus.tx_busy) begin
          state_nxt_s = ST_START;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt_s    = ST_WAIT_BUSY;
        wait_cnt_nxt_s = '0;
      end
      ST_WAIT_BUSY: begin
        // A busy seen on the last allowed cycle still wins over the timeout.
        if (bus.tx_busy) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (wait_cnt_r == TO_LAST) begin
          state_nxt_s = ST_IDLE;
          timeout_s   = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + TO_ONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_nxt_s   = ST_GAP;
          gap_cnt_nxt_s = '0;
          done_s        = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + GAP_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    drop_s = rise_s & ~accept_s;
  end

  // State, timers, captured data and status counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      btn_prev_r    <= 1'b1;
      wait_cnt_r    <= '0;
      gap_cnt_r     <= '0;
      tx_start_r    <= 1'b0;
      press_pulse_r <= 1'b0;
      tx_data_r     <= '0;
      send_count_r  <= 8'd0;
      drop_count_r  <= 8'd0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      btn_prev_r    <= bus.btn_level;
      wait_cnt_r    <= wait_cnt_nxt_s;
      gap_cnt_r     <= gap_cnt_nxt_s;
      tx_start_r    <= accept_s;
      press_pulse_r <= accept_s;
      if (accept_s) begin
        tx_data_r <= bus.data_in;
      end
      if (done_s) begin
        send_count_r <= sat_inc8(send_count_r);
      end
      if (drop_s) begin
        drop_count_r <= sat_inc8(drop_count_r);
      end
      if (timeout_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  assign bus.tx_start    = tx_start_r;
  assign bus.press_pulse = press_pulse_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.send_count  = send_count_r;
  assign bus.drop_count  = drop_count_r;
  assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_switch_tx_trigger.sv
// Bench for switch_tx_trigger: directed scenarios plus random button traffic,
// checked every cycle against a timestamp-based model of press outcomes.
module tb_switch_tx_trigger;
  localparam int DW     = 8;
  localparam int TO     = 16;
  localparam int GAP    = 20;
  localparam int NSCHED = 32768;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  switch_tx_trigger_if #(.DATA_W(DW)) bus ();

  switch_tx_trigger #(
    .DATA_W(DW), .ACCEPT_TIMEOUT(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  // Stimulus knobs
  int         cyc = 0;
  bit         busy_sched [NSCHED];
  logic       rst_drv = 1'b0;
  logic       btn_drv = 1'b0;
  logic       force_busy = 1'b0;
  logic [7:0] data_drv = 8'd0;
  bit         resp_never = 1'b0;
  int         resp_d = 3;
  int         resp_l = 10;

  // Reference model: when the trigger is free again and what it has reported
  bit         m_prev = 1'b1;
  int         idle_from = 0;
  logic [7:0] m_data = 8'd0, m_send = 8'd0, m_drop = 8'd0;
  bit         m_err = 1'b0, m_pulse = 1'b0;
  int         done_q[$];
  int         to_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check on the falling edge.
  task automatic tick();
    int   e;
    int   b;
    logic busy_in;
    logic rise_m;
    e       = cyc + 1;
    busy_in = force_busy | ((e < NSCHED) ? busy_sched[e] : 1'b0);
    bus.btn_level = btn_drv;
    bus.data_in   = data_drv;
    bus.tx_busy   = busy_in;
    rst_n         = rst_drv;
    @(posedge clk);
    cyc     = e;
    m_pulse = 1'b0;
    if (!rst_drv) begin
      m_prev = 1'b1; m_send = 8'd0; m_drop = 8'd0; m_err = 1'b0; m_data = 8'd0;
      idle_from = e + 1;
      done_q.delete();
      to_q.delete();
    end else begin
      rise_m = btn_drv & ~m_prev;
      m_prev = btn_drv;
      if (done_q.size() > 0 && done_q[0] == e) begin
        void'(done_q.pop_front());
        m_send = sat8(m_send);
      end
      if (to_q.size() > 0 && to_q[0] == e) begin
        void'(to_q.pop_front());
        m_err = 1'b1;
      end
      if (rise_m) begin
        if (e >= idle_from && !busy_in) begin
          m_pulse = 1'b1;
          m_data  = data_drv;
          if (resp_never) begin
            to_q.push_back(e + 1 + TO);
            idle_from = e + 2 + TO;
          end else begin
            b = e + 1 + resp_d;
            for (int i = b; i < b + resp_l; i++) if (i < NSCHED) busy_sched[i] = 1'b1;
            done_q.push_back(b + resp_l);
            idle_from = b + resp_l + GAP + 1;
          end
        end else begin
          m_drop = sat8(m_drop);
        end
      end
    end
    @(negedge clk);
    chk("press_pulse", 32'(bus.press_pulse), 32'(m_pulse));
    chk("tx_start",    32'(bus.tx_start),    32'(m_pulse));
    chk("tx_data",     32'(bus.tx_data),     32'(m_data));
    chk("send_count",  32'(bus.send_count),  32'(m_send));
    chk("drop_count",  32'(bus.drop_count),  32'(m_drop));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input logic [7:0] d);
    data_drv = d;
    btn_drv  = 1'b1;
    tick();
    btn_drv  = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      if (cyc + 1 >= idle_from && !busy_sched[cyc + 1]) break;
      tick();
    end
  endtask

  initial begin
    // 1: button held through reset gives no edge; only the later press is served
    rst_drv = 1'b0; btn_drv = 1'b1;
    idle(3);
    rst_drv = 1'b1;
    idle(3);
    btn_drv = 1'b0;
    tick();
    resp_d = 2; resp_l = 4;
    press(8'h3C);
    wait_idle();
    chk("t1_send", 32'(bus.send_count), 32'd1);
    chk("t1_drop", 32'(bus.drop_count), 32'd0);

    // 2 + 3: A5 frame, then presses during WAIT_DONE and during GAP are dropped
    resp_d = 3; resp_l = 10;
    press(8'hA5);
    chk("t2_data", 32'(bus.tx_data), 32'hA5);
    idle(4);
    press(8'h11);
    idle(10);
    press(8'h22);
    wait_idle();
    chk("t3_send", 32'(bus.send_count), 32'd2);
    chk("t3_drop", 32'(bus.drop_count), 32'd2);
    chk("t2_err",  32'(bus.timeout_err), 32'd0);
    chk("t2_hold", 32'(bus.tx_data), 32'hA5);

    // 4: transmitter never accepts
    rst_drv = 1'b0; idle(2); rst_drv = 1'b1; tick();
    resp_never = 1'b1;
    press(8'h77);
    idle(TO);
    chk("t4_err",  32'(bus.timeout_err), 32'd1);
    chk("t4_send", 32'(bus.send_count), 32'd0);
    resp_never = 1'b0;
    wait_idle();

    // 5: saturation of send_count, then a press blocked by busy in IDLE
    for (int i = 0; i < 300; i++) begin
      resp_d = $urandom_range(1, 6);
      resp_l = $urandom_range(1, 6);
      press(8'($urandom));
      wait_idle();
    end
    chk("t5_send_sat", 32'(bus.send_count), 32'd255);
    force_busy = 1'b1;
    press(8'h99);
    force_busy = 1'b0;
    chk("t5_drop", 32'(bus.drop_count), 32'd1);

    // Random button traffic with random transmitter behaviour
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) btn_drv = ~btn_drv;
      data_drv   = 8'($urandom);
      force_busy = (cyc + 1 >= idle_from) && ($urandom_range(0, 15) == 0);
      resp_never = ($urandom_range(0, 5) == 0);
      resp_d     = $urandom_range(1, TO);
      resp_l     = $urandom_range(1, 12);
      tick();
    end
    force_busy = 1'b0; btn_drv = 1'b0; resp_never = 1'b0;
    tick();
    wait_idle();

    // 6: reset in the middle of a frame
    resp_d = 2; resp_l = 30;
    press(8'h5A);
    idle(6);
    rst_drv = 1'b0;
    tick();
    chk("t6_start", 32'(bus.tx_start), 32'd0);
    chk("t6_data",  32'(bus.tx_data), 32'd0);
    chk("t6_send",  32'(bus.send_count), 32'd0);
    chk("t6_drop",  32'(bus.drop_count), 32'd0);
    chk("t6_err",   32'(bus.timeout_err), 32'd0);
    rst_drv = 1'b1;
    idle(40);
    resp_d = 1; resp_l = 4;
    press(8'hC3);
    wait_idle();
    chk("t6_resend", 32'(bus.send_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
